led_top: RTL and testbench

//  Self-contained HUB75 driver for a 64x32 RGB LED panel at 1/16 scan. It generates a built-in 3-bit-colour

---
 rtl/led_pkg.sv | 19 +
 rtl/led_pattern_gen.sv | 21 ++
 rtl/led_top.sv | 194 +++++++++++++++++++
 tb/tb_led_top.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the HUB75 64x32 LED panel driver.
package led_pkg;

    typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;

    typedef logic [2:0] colour_t;

    localparam int DEF_PANEL_WIDTH = 64;
    localparam int DEF_SCAN_ROWS   = 16;
    localparam int ROW_W           = 4;

    // Diagonal stripe test pattern; the 3-bit sum wraps naturally.
    function automatic colour_t pattern_colour(input logic [2:0] col_group,
                                               input logic [2:0] row_low,
                                               input logic [2:0] phase);
        return colour_t'(col_group + row_low + phase);
    endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Combinational test-pattern source: 8-column stripes shifted by row and phase,
// lower half of the panel shows the complement of the upper half.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int COL_W = 6
) (
    input  logic [COL_W-1:0] col,
    input  logic [2:0]       row,
    input  logic [2:0]       phase,
    output colour_t          top,
    output colour_t          bottom
);

    colour_t c;

    assign c      = pattern_colour(3'(col >> 3), row, phase);
    assign top    = c;
    assign bottom = ~c;

endmodule

// File: rtl/led_top.sv
// HUB75 driver for a 64x32 panel at 1/16 scan: shifts a built-in pattern per row,
// latches it, then holds the row lit while the next row is shifted in.
module led_top
    import led_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int PANEL_WIDTH = DEF_PANEL_WIDTH,
    parameter int SCAN_ROWS   = DEF_SCAN_ROWS,
    parameter int ON_TICKS    = 64,
    parameter int STEP_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic R0,
    output logic G0,
    output logic B0,
    output logic R1,
    output logic G1,
    output logic B1,
    output logic OE,
    output logic LAT,
    output logic SCLK
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int COL_W   = $clog2(PANEL_WIDTH);
    localparam int DWELL_W = $clog2(ON_TICKS + 1);
    localparam int FRAME_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(PANEL_WIDTH - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ON_TICKS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(STEP_FRAMES - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(SCAN_ROWS - 1);

    logic [DIV_W-1:0]   div;
    logic               tick;

    state_t             state, state_n;
    logic               hi, hi_n;
    logic [COL_W-1:0]   col, col_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [2:0]         phase, phase_n;
    logic [FRAME_W-1:0] frame, frame_n;
    logic [DWELL_W-1:0] dwell, dwell_n;

    logic [ROW_W-1:0]   addr, addr_n;
    colour_t            top_rgb, top_rgb_n, bot_rgb, bot_rgb_n;
    logic               sclk_q, sclk_n, oe_q, oe_n, lat_q, lat_n;

    colour_t            pat_top, pat_bot;

    led_pattern_gen #(
        .COL_W (COL_W)
    ) u_pattern (
        .col    (col),
        .row    (row[2:0]),
        .phase  (phase),
        .top    (pat_top),
        .bottom (pat_bot)
    );

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Every state and output register moves together; the next-state block
    // holds them unchanged between ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SHIFT;
            hi      <= 1'b0;
            col     <= '0;
            row     <= '0;
            phase   <= '0;
            frame   <= '0;
            dwell   <= '0;
            addr    <= '0;
            top_rgb <= '0;
            bot_rgb <= '0;
            sclk_q  <= 1'b0;
            oe_q    <= 1'b0;
            lat_q   <= 1'b0;
        end else begin
            state   <= state_n;
            hi      <= hi_n;
            col     <= col_n;
            row     <= row_n;
            phase   <= phase_n;
            frame   <= frame_n;
            dwell   <= dwell_n;
            addr    <= addr_n;
            top_rgb <= top_rgb_n;
            bot_rgb <= bot_rgb_n;
            sclk_q  <= sclk_n;
            oe_q    <= oe_n;
            lat_q   <= lat_n;
        end
    end

    always_comb begin
        state_n   = state;
        hi_n      = hi;
        col_n     = col;
        row_n     = row;
        phase_n   = phase;
        frame_n   = frame;
        dwell_n   = dwell;
        addr_n    = addr;
        top_rgb_n = top_rgb;
        bot_rgb_n = bot_rgb;
        sclk_n    = sclk_q;
        oe_n      = oe_q;
        lat_n     = lat_q;

        if (tick) begin
            unique case (state)
                SHIFT: begin
                    // Low half-bit presents data, high half-bit clocks it in.
                    if (!hi) begin
                        sclk_n    = 1'b0;
                        top_rgb_n = pat_top;
                        bot_rgb_n = pat_bot;
                        hi_n      = 1'b1;
                    end else begin
                        sclk_n = 1'b1;
                        hi_n   = 1'b0;
                        if (col == COL_LAST) begin
                            col_n   = '0;
                            state_n = BLANK;
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end
                end
                BLANK: begin
                    sclk_n    = 1'b0;
                    oe_n      = 1'b1;
                    top_rgb_n = '0;
                    bot_rgb_n = '0;
                    state_n   = LATCH;
                end
                LATCH: begin
                    lat_n   = 1'b1;
                    oe_n    = 1'b1;
                    dwell_n = '0;
                    state_n = DISPLAY;
                end
                DISPLAY: begin
                    lat_n = 1'b0;
                    oe_n  = 1'b0;
                    if (dwell == '0) begin
                        addr_n = row;
                    end
                    if (dwell == DWELL_LAST) begin
                        dwell_n = '0;
                        state_n = SHIFT;
                        row_n   = row + 1'b1;
                        if (row == ROW_LAST) begin
                            if (frame == FRAME_LAST) begin
                                frame_n = '0;
                                phase_n = phase + 3'd1;
                            end else begin
                                frame_n = frame + 1'b1;
                            end
                        end
                    end else begin
                        dwell_n = dwell + 1'b1;
                    end
                end
            endcase
        end
    end

    assign {D, C, B, A}    = addr;
    assign {R0, G0, B0}    = top_rgb;
    assign {R1, G1, B1}    = bot_rgb;
    assign OE              = oe_q;
    assign LAT             = lat_q;
    assign SCLK            = sclk_q;

endmodule

// File: tb/tb_led_top.sv
// Directed bench for led_top: startup latency, per-row shift/latch/dwell timing,
// row addressing, pattern colours including the phase step, and async reset.
module tb_led_top;

    localparam int CLK_DIV     = 4;
    localparam int PANEL_WIDTH = 64;
    localparam int ON_TICKS    = 64;
    localparam int STEP_FRAMES = 2;
    localparam int ROW_CLKS    = (2 * PANEL_WIDTH + 2 + ON_TICKS) * CLK_DIV;
    localparam int NUM_LATS    = 33;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT, SCLK;

    logic [3:0]  addr;
    logic [12:0] allOut;

    assign addr   = {D, C, B, A};
    assign allOut = {A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT, SCLK};

    always #5 clk = ~clk;

    led_top #(
        .CLK_DIV     (CLK_DIV),
        .PANEL_WIDTH (PANEL_WIDTH),
        .SCAN_ROWS   (16),
        .ON_TICKS    (ON_TICKS),
        .STEP_FRAMES (STEP_FRAMES)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .C    (C),
        .D    (D),
        .R0   (R0),
        .G0   (G0),
        .B0   (B0),
        .R1   (R1),
        .G1   (G1),
        .B1   (B1),
        .OE   (OE),
        .LAT  (LAT),
        .SCLK (SCLK)
    );

    int checkCount  = 0;
    int errCount    = 0;
    int cyc         = 0;
    int latSclkViol = 0;
    int addrViol    = 0;

    logic       prevSclk = 1'b0;
    logic       prevLat  = 1'b0;
    logic       prevOe   = 1'b0;
    logic [3:0] prevAddr = 4'd0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstLevel);
        rst = rstLevel;
    endtask

    // One clock, sampled 1 ns after the edge, with protocol invariants tracked.
    task automatic stepClk();
        prevSclk = SCLK;
        prevLat  = LAT;
        prevOe   = OE;
        prevAddr = addr;
        @(posedge clk);
        #1;
        cyc++;
        if (LAT && SCLK) latSclkViol++;
        if ((addr != prevAddr) && !prevOe) addrViol++;
    endtask

    task automatic timeoutAbort(input string tag);
        checkOutput(tag, 32'd1, 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $fatal(1, "[TB] stopped: wait bound expired");
    endtask

    task automatic measureStartup(output int n);
        n = 0;
        do begin
            stepClk();
            n++;
        end while (!SCLK && n < 50);
    endtask

    initial begin
        int n;
        int rises;
        int oeHigh;
        int lastLatCyc;
        int lastLatFallCyc;
        logic [2:0] col0Top, col0Bot, col8Top, col56Top;

        applyStimulus(1'b0);
        #25;
        checkOutput("reset_outputs", 32'(allOut), 32'd0);
        #5;
        applyStimulus(1'b1);

        measureStartup(n);
        checkOutput("startup_clks", 32'(n), 32'(2 * CLK_DIV));

        col0Top        = {R0, G0, B0};
        col0Bot        = {R1, G1, B1};
        col8Top        = 3'd0;
        col56Top       = 3'd0;
        rises          = 1;
        oeHigh         = 0;
        lastLatCyc     = 0;
        lastLatFallCyc = 0;

        for (int k = 1; k <= NUM_LATS; k++) begin
            int waited;
            int latW;
            int row;
            int frame;
            int phase;
            int c;

            waited = 0;
            while (!(LAT && !prevLat)) begin
                stepClk();
                waited++;
                if (waited > 1000) timeoutAbort("lat_wait");
                if (OE) oeHigh++;
                if (OE && !prevOe && k > 1)
                    checkOutput("oe_low_min", 32'((cyc - lastLatFallCyc) >= ON_TICKS * CLK_DIV), 32'd1);
                if (SCLK && !prevSclk) begin
                    if (rises == 0)  begin col0Top = {R0, G0, B0}; col0Bot = {R1, G1, B1}; end
                    if (rises == 8)  col8Top  = {R0, G0, B0};
                    if (rises == 56) col56Top = {R0, G0, B0};
                    rises++;
                end
            end

            row   = (k - 1) % 16;
            frame = (k - 1) / 16;
            phase = (frame / STEP_FRAMES) % 8;
            c     = (row % 8 + phase) % 8;

            if (k > 1) checkOutput("row_period", 32'(cyc - lastLatCyc), 32'(ROW_CLKS));
            lastLatCyc = cyc;
            checkOutput("sclk_per_row", 32'(rises), 32'(PANEL_WIDTH));
            checkOutput("col0_top", 32'(col0Top), 32'(c));
            checkOutput("col0_bot", 32'(col0Bot), 32'(7 - c));
            checkOutput("col8_top", 32'(col8Top), 32'((c + 1) % 8));
            checkOutput("col56_top", 32'(col56Top), 32'((c + 7) % 8));

            latW = 1;
            do begin
                stepClk();
                if (OE) oeHigh++;
                if (LAT) latW++;
            end while (LAT && latW <= 20);
            if (LAT) timeoutAbort("lat_stuck");

            checkOutput("lat_width", 32'(latW), 32'(CLK_DIV));
            checkOutput("oe_high_width", 32'(oeHigh), 32'(2 * CLK_DIV));
            checkOutput("row_addr", 32'(addr), 32'(row));
            checkOutput("oe_on_after_lat", 32'(OE), 32'd0);

            lastLatFallCyc = cyc;
            oeHigh         = 0;
            rises          = 0;
        end

        checkOutput("lat_sclk_overlap", 32'(latSclkViol), 32'd0);
        checkOutput("addr_change_while_lit", 32'(addrViol), 32'd0);

        // Pull reset in the middle of the next row's shift.
        n = 0;
        while (!SCLK) begin
            stepClk();
            n++;
            if (n > 600) timeoutAbort("shift_wait");
        end
        repeat (6) stepClk();
        #2;
        applyStimulus(1'b0);
        #1;
        checkOutput("async_reset", 32'(allOut), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", 32'(allOut), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1);

        measureStartup(n);
        checkOutput("restart_clks", 32'(n), 32'(2 * CLK_DIV));
        checkOutput("restart_col0_top", 32'({R0, G0, B0}), 32'd0);
        checkOutput("restart_col0_bot", 32'({R1, G1, B1}), 32'd7);
        checkOutput("restart_addr", 32'(addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
